// File: rtl/sprite_capture5x5.sv
// sprite_capture5x5: listens to the 5x5 sprite plotter's pixel-write stream
// and rebuilds the sprite it drew (origin, 25-bit raster mask, foreground
// colour). It only observes the plot wires and never drives them.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_IDLE    | waiting for the first plot strobe of a sprite
//   S_CAPTURE | checking and recording pixels 1..24 in raster order
//   S_DONE    | result presented (valid=1), frozen until ack
module sprite_capture5x5 (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        plot,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  input  logic [2:0]  colour,
  input  logic        ack,
  output logic [24:0] shape,
  output logic [7:0]  x_org,
  output logic [6:0]  y_org,
  output logic [2:0]  fg_colour,
  output logic        valid,
  output logic        error,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  col, row, col_nxt, row_nxt;
  logic [24:0] shape_nxt;
  logic [7:0]  x_org_nxt;
  logic [6:0]  y_org_nxt;
  logic [2:0]  fg_colour_nxt;
  logic        valid_nxt, error_nxt, busy_nxt;

  logic [7:0]  exp_x;
  logic [6:0]  exp_y;
  logic [4:0]  pix_idx;
  logic [4:0]  bit_pos;
  logic        non_black;
  logic        coord_ok;

  // Expected coordinate of the current pixel; the adders wrap naturally at
  // the screen width/height, matching the plotter's own arithmetic.
  always_comb begin
    exp_x     = x_org + {5'd0, col};
    exp_y     = y_org + {4'd0, row};
    pix_idx   = ({2'd0, row} << 2) + {2'd0, row} + {2'd0, col};
    bit_pos   = 5'd24 - pix_idx;
    non_black = (colour != 3'b000);
    coord_ok  = (x == exp_x) && (y == exp_y);
  end

  // State, index and result registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      col       <= 3'd0;
      row       <= 3'd0;
      shape     <= 25'd0;
      x_org     <= 8'd0;
      y_org     <= 7'd0;
      fg_colour <= 3'd0;
      valid     <= 1'b0;
      error     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      col       <= col_nxt;
      row       <= row_nxt;
      shape     <= shape_nxt;
      x_org     <= x_org_nxt;
      y_org     <= y_org_nxt;
      fg_colour <= fg_colour_nxt;
      valid     <= valid_nxt;
      error     <= error_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state and next-output logic; outputs are registered so valid/busy
  // are computed alongside the state they belong to.
  always_comb begin
    state_nxt     = state;
    col_nxt       = col;
    row_nxt       = row;
    shape_nxt     = shape;
    x_org_nxt     = x_org;
    y_org_nxt     = y_org;
    fg_colour_nxt = fg_colour;
    valid_nxt     = valid;
    error_nxt     = error;
    busy_nxt      = busy;

    case (state)
      S_IDLE: begin
        if (plot) begin
          x_org_nxt     = x;
          y_org_nxt     = y;
          shape_nxt     = 25'd0;
          shape_nxt[24] = non_black;
          fg_colour_nxt = colour;
          error_nxt     = 1'b0;
          col_nxt       = 3'd1;
          row_nxt       = 3'd0;
          busy_nxt      = 1'b1;
          state_nxt     = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        if (!plot || !coord_ok) begin
          // A gap or a stray coordinate ends the capture; bits not yet
          // reached stay zero.
          error_nxt = 1'b1;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b0;
          col_nxt   = 3'd0;
          row_nxt   = 3'd0;
          state_nxt = S_DONE;
        end else begin
          shape_nxt[bit_pos] = non_black;
          if (non_black) begin
            if (fg_colour == 3'b000) begin
              fg_colour_nxt = colour;
            end else if (colour != fg_colour) begin
              // Two-colour sprite: keep capturing, report at the end.
              error_nxt = 1'b1;
            end
          end
          if (col == 3'd4 && row == 3'd4) begin
            valid_nxt = 1'b1;
            busy_nxt  = 1'b0;
            col_nxt   = 3'd0;
            row_nxt   = 3'd0;
            state_nxt = S_DONE;
          end else if (col == 3'd4) begin
            col_nxt = 3'd0;
            row_nxt = row + 3'd1;
          end else begin
            col_nxt = col + 3'd1;
          end
        end
      end

      S_DONE: begin
        // plot is deliberately ignored here, even together with ack.
        if (ack) begin
          valid_nxt = 1'b0;
          error_nxt = 1'b0;
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
        valid_nxt = 1'b0;
        error_nxt = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sprite_capture5x5.sv
// tb_sprite_capture5x5: directed and randomized sprite streams checked
// against a transaction-level model of the capture rules.
module tb_sprite_capture5x5;

  logic        clock;
  logic        reset_n;
  logic        plot;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        ack;
  logic [24:0] shape;
  logic [7:0]  x_org;
  logic [6:0]  y_org;
  logic [2:0]  fg_colour;
  logic        valid;
  logic        error;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // pixel stream for one sprite, index = 5*row + col
  logic        p_plot [25];
  logic [7:0]  p_x    [25];
  logic [6:0]  p_y    [25];
  logic [2:0]  p_c    [25];

  // expected result of the most recent capture
  int          e_end;
  logic [24:0] e_shape;
  logic [2:0]  e_fg;
  logic        e_err;
  logic [7:0]  e_xo;
  logic [6:0]  e_yo;

  sprite_capture5x5 dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .plot      (plot),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .ack       (ack),
    .shape     (shape),
    .x_org     (x_org),
    .y_org     (y_org),
    .fg_colour (fg_colour),
    .valid     (valid),
    .error     (error),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_clean(input logic [7:0] ox, input logic [6:0] oy,
                             input logic [24:0] mask, input logic [2:0] c);
    for (int i = 0; i < 25; i++) begin
      p_plot[i] = 1'b1;
      p_x[i]    = 8'(ox + 8'(i % 5));
      p_y[i]    = 7'(oy + 7'(i / 5));
      p_c[i]    = mask[24 - i] ? c : 3'b000;
    end
  endtask

  // Reference: walk the pixel list in raster order applying the rules.
  task automatic model();
    int ox, oy;
    ox = p_x[0];
    oy = p_y[0];
    e_xo = p_x[0];
    e_yo = p_y[0];
    e_shape = 25'd0;
    e_fg = 3'b000;
    e_err = 1'b0;
    e_end = 24;
    for (int i = 0; i < 25; i++) begin
      if (i > 0 && (!p_plot[i] || int'(p_x[i]) != (ox + i % 5) % 256
                               || int'(p_y[i]) != (oy + i / 5) % 128)) begin
        e_err = 1'b1;
        e_end = i;
        break;
      end
      if (p_c[i] != 3'b000) begin
        e_shape[24 - i] = 1'b1;
        if (e_fg == 3'b000) e_fg = p_c[i];
        else if (p_c[i] != e_fg) e_err = 1'b1;
      end
    end
  endtask

  task automatic check_result(input string name);
    check_val({name, " valid"}, 32'(valid), 32'd1);
    check_val({name, " busy"}, 32'(busy), 32'd0);
    check_val({name, " error"}, 32'(error), 32'(e_err));
    check_val({name, " shape"}, 32'(shape), 32'(e_shape));
    check_val({name, " fg"}, 32'(fg_colour), 32'(e_fg));
    check_val({name, " x_org"}, 32'(x_org), 32'(e_xo));
    check_val({name, " y_org"}, 32'(y_org), 32'(e_yo));
  endtask

  // Drives the stream one pixel per clock; stops at the expected end.
  task automatic run_capture(input string name);
    model();
    for (int i = 0; i < 25; i++) begin
      plot   = p_plot[i];
      x      = p_x[i];
      y      = p_y[i];
      colour = p_c[i];
      @(posedge clock);
      #1;
      if (i < e_end) begin
        check_val({name, " busy_run"}, 32'(busy), 32'd1);
        check_val({name, " valid_run"}, 32'(valid), 32'd0);
      end else begin
        check_result(name);
        break;
      end
    end
    plot = 1'b0;
  endtask

  task automatic do_ack(input string name);
    ack = 1'b1;
    @(posedge clock);
    #1;
    ack = 1'b0;
    check_val({name, " ack_valid"}, 32'(valid), 32'd0);
    check_val({name, " ack_error"}, 32'(error), 32'd0);
    check_val({name, " ack_shape_held"}, 32'(shape), 32'(e_shape));
  endtask

  task automatic check_all_zero(input string name);
    check_val({name, " shape0"}, 32'(shape), 32'd0);
    check_val({name, " xo0"}, 32'(x_org), 32'd0);
    check_val({name, " yo0"}, 32'(y_org), 32'd0);
    check_val({name, " fg0"}, 32'(fg_colour), 32'd0);
    check_val({name, " valid0"}, 32'(valid), 32'd0);
    check_val({name, " error0"}, 32'(error), 32'd0);
    check_val({name, " busy0"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [24:0] m;
    logic [2:0]  c;
    int          k, kind;

    reset_n = 1'b1;
    plot = 1'b0; x = 8'd0; y = 7'd0; colour = 3'd0; ack = 1'b0;
    #3 reset_n = 1'b0;
    #10;
    check_all_zero("reset");
    #9 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // reference sprite
    build_clean(8'd10, 7'd15, 25'b0111011111110001111101110, 3'b110);
    run_capture("basic");
    check_val("basic shape_const", 32'(shape), 32'h0EFE3EE);
    do_ack("basic");

    // coordinate wrap at both screen edges
    build_clean(8'd254, 7'd126, 25'h1FFFFFF, 3'b001);
    run_capture("wrap");
    do_ack("wrap");

    // all black
    build_clean(8'd40, 7'd20, 25'd0, 3'b101);
    run_capture("black");
    do_ack("black");

    // gap at pixel 7
    build_clean(8'd3, 7'd4, 25'h1FFFFFF, 3'b010);
    p_plot[7] = 1'b0;
    run_capture("gap");
    check_val("gap shape_const", 32'(shape), 32'h1FC0000);
    do_ack("gap");

    // pixel 12 off by one in x
    build_clean(8'd100, 7'd50, 25'h1FFFFFF, 3'b011);
    p_x[12] = p_x[12] + 8'd1;
    run_capture("xoff");
    do_ack("xoff");

    // colour mismatch: pixel 0 colour 6, pixel 6 colour 3
    build_clean(8'd60, 7'd60, 25'h1FFFFFF, 3'b110);
    p_c[6] = 3'b011;
    run_capture("colmis");
    check_val("colmis err_const", 32'(error), 32'd1);
    do_ack("colmis");

    // reset in the middle of a capture
    build_clean(8'd77, 7'd33, 25'h15A5A5A, 3'b100);
    for (int i = 0; i < 10; i++) begin
      plot = p_plot[i]; x = p_x[i]; y = p_y[i]; colour = p_c[i];
      @(posedge clock);
      #1;
    end
    reset_n = 1'b0;
    #2;
    check_all_zero("midreset");
    plot = 1'b0;
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    run_capture("after_reset");
    do_ack("after_reset");

    // DONE holds while plot toggles and ack stays low
    build_clean(8'd5, 7'd9, 25'h0AAAAAA, 3'b111);
    run_capture("hold");
    for (int i = 0; i < 100; i++) begin
      plot = 1'($urandom); x = 8'($urandom); y = 7'($urandom); colour = 3'($urandom);
      @(posedge clock);
      #1;
      check_val("hold valid", 32'(valid), 32'd1);
      check_val("hold busy", 32'(busy), 32'd0);
      check_val("hold shape", 32'(shape), 32'(e_shape));
      check_val("hold xo", 32'(x_org), 32'(e_xo));
    end
    // ack with plot on the same cycle: plot ignored
    build_clean(8'd200, 7'd100, 25'h1F0F0F0, 3'b010);
    ack = 1'b1; plot = 1'b1; x = p_x[0]; y = p_y[0]; colour = p_c[0];
    @(posedge clock);
    #1;
    ack = 1'b0; plot = 1'b0;
    check_val("ackplot valid", 32'(valid), 32'd0);
    check_val("ackplot busy", 32'(busy), 32'd0);
    check_val("ackplot xo_held", 32'(x_org), 32'd5);
    run_capture("after_ackplot");
    do_ack("after_ackplot");

    // randomized sprites with random faults
    for (int t = 0; t < 40; t++) begin
      m = 25'($urandom);
      c = 3'($urandom_range(7, 1));
      build_clean(8'($urandom), 7'($urandom), m, c);
      kind = $urandom_range(4, 0);
      k = $urandom_range(24, 1);
      case (kind)
        1: p_plot[k] = 1'b0;
        2: p_x[k] = p_x[k] + 8'd1;
        3: p_y[k] = p_y[k] - 7'd1;
        4: p_c[k] = 3'((int'(c) % 7) + 1);
        default: ;
      endcase
      run_capture("rand");
      do_ack("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_capture5x5.md
# sprite_capture5x5

Receive-side counterpart of the 5x5 sprite plotter. Consumes the plotter's pixel-write stream (plot, x, y, colour) and reconstructs the sprite it drew: origin, 25-bit shape mask (bit 24 = top-left, raster order) and foreground colour. Used as an in-fabric checker on the plot bus and as the source of sprite occupancy for game logic (collision, pellet detection). Sits in parallel with the VGA adapter on the same plot wires; never drives them.

## Interface
Parameters: none; sprite size is fixed at 5x5.

Ports:
- clock  in  1  system clock (CLOCK_50 domain)
- reset_n  in  1  asynchronous, active-low reset
- plot  in  1  pixel-write strobe from the plotter
- x  in  8  pixel x coordinate
- y  in  7  pixel y coordinate
- colour  in  3  pixel colour; 3'b000 is background
- ack  in  1  consumer has taken the result
- shape  out  25  captured mask; bit 24-(5*row+col) is set iff pixel (col,row) was non-black
- x_org  out  8  x of the first captured pixel
- y_org  out  7  y of the first captured pixel
- fg_colour  out  3  colour of the non-black pixels
- valid  out  1  result ready; held until ack
- error  out  1  qualifies valid; capture was malformed
- busy  out  1  capture in progress

## Operation
- FSM states: IDLE, CAPTURE, DONE.
- IDLE: busy=0, valid=0. On plot=1:
  - latch x_org=x, y_org=y;
  - clear shape and set bit 24 to (colour!=0);
  - fg_colour=colour if non-zero, else 0;
  - index=1 (col=1, row=0); go to CAPTURE.
- CAPTURE: busy=1. Each cycle plot=1 must carry:
  - expected x = x_org+col, mod 256;
  - expected y = y_org+row, mod 128.
- On a matching pixel, set shape[24-(5*row+col)] = (colour!=0).
- Foreground colour check on a matching non-black pixel:
  - if fg_colour==0, set fg_colour=colour;
  - if fg_colour!=0 and colour!=fg_colour, set the error flag.
- Index advance: col 0..4, then row+1 with col=0. The cycle that samples (col4,row4) moves to DONE.
- Error conditions, each moving to DONE with error=1:
  - plot=0 in CAPTURE (gap in the stream);
  - a coordinate mismatch.
- Shape bits not yet captured stay 0 when an error occurs.
- The error flag is sticky through a capture.
- A colour mismatch does not abort the capture; it is reported at DONE.
- DONE: valid=1, busy=0; outputs frozen. plot pulses are ignored and cannot start a capture.
  - ack=1 → IDLE, valid=0, error=0.
  - shape, x_org, y_org and fg_colour keep their values until the next capture starts.
- All-black sprite: valid with shape=0, fg_colour=0, error=0.

## Timing
- Reset (async, any state, including mid-capture): state=IDLE, shape=0, x_org=0, y_org=0, fg_colour=0, valid=0, error=0, busy=0, index=0.
- All outputs are registered and change only on the rising edge of clock.
- The plot stream is sampled on the same edge the VGA adapter samples it. No input skid; every plot cycle is one pixel.
- Latency: 25 consecutive plot cycles starting at edge N → valid=1 after edge N+24. busy=1 after edges N..N+23.
- Error abort: valid=1, error=1 after the edge that samples the offending cycle.
- DONE with ack=1 and plot=1 on the same cycle: valid clears, plot is ignored. The next capture needs plot sampled in IDLE, one cycle later at the earliest.
- ack in IDLE or CAPTURE: no effect.
- Back-to-back sprites with no gap: the second sprite's first pixel is lost if it arrives while in DONE. The plotter's WAIT/load cycle plus a same-cycle ack guarantees one IDLE cycle.

## Test plan
- Sprite 25'b0111011111110001111101110, colour 3'b110, origin (10,15), 25 consecutive plots → valid after 25 edges; shape=0x0EFE3EE; x_org=10, y_org=15, fg_colour=6, error=0.
- Origin (254,126), full mask, colour 3'b001 → x wraps 254,255,0,1,2 and y wraps 126,127,0,1,2; valid, shape=0x1FFFFFF, error=0.
- plot drops after pixel 7 → valid=1, error=1 on the next edge; shape holds only bits 24..18 as captured.
- Pixel 12 sent with x off by one → error=1, valid=1 after that edge.
- Colour mismatch: pixel 0 colour 6, pixel 6 colour 3 → capture completes at 25, error=1.
- Reset pulse at pixel 10, then a full clean sprite → all outputs 0 immediately after reset; the second capture is correct.
- Hold ack=0 in DONE for 100 cycles while plot toggles → outputs stable. Then ack=1 with plot=1 → valid=0; the new capture starts on the following plot.
